// File: rtl/morra_pkg.sv
// Shared types, defaults and the move-beats-move rule for the morra match engine.
package morra_pkg;

  localparam int DEF_MIN_ROUNDS = 4;
  localparam int DEF_WIN_MARGIN = 2;
  localparam int DEF_CNT_W      = 5;

  typedef enum logic [1:0] {
    MOVE_NONE     = 2'b00,
    MOVE_ROCK     = 2'b01,
    MOVE_PAPER    = 2'b10,
    MOVE_SCISSORS = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    ROUND_VOID = 2'b00,
    ROUND_P1   = 2'b01,
    ROUND_P2   = 2'b10,
    ROUND_DRAW = 2'b11
  } round_res_e;

  typedef enum logic [1:0] {
    GAME_NONE = 2'b00,
    GAME_P1   = 2'b01,
    GAME_P2   = 2'b10,
    GAME_TIE  = 2'b11
  } game_res_e;

  // Last round winner and the move it won with; that move is barred next round.
  typedef struct packed {
    logic  valid;
    logic  owner_p2;
    move_e move;
  } lock_t;

  function automatic logic beats(input move_e a, input move_e b);
    return ((a == MOVE_ROCK)     && (b == MOVE_SCISSORS)) ||
           ((a == MOVE_PAPER)    && (b == MOVE_ROCK))     ||
           ((a == MOVE_SCISSORS) && (b == MOVE_PAPER));
  endfunction

endpackage

// File: rtl/morra_round_judge.sv
// Combinational judge for a single round: result plus the lock to carry forward.
module morra_round_judge
  import morra_pkg::*;
(
  input  move_e      p1,
  input  move_e      p2,
  input  lock_t      lock_cur,
  output round_res_e res,
  output lock_t      lock_next
);

  logic missing_move;
  logic locked_repeat;

  // A missing move or the locked winner reusing its move voids the round and keeps the lock.
  always_comb begin
    missing_move  = (p1 == MOVE_NONE) || (p2 == MOVE_NONE);
    locked_repeat = lock_cur.valid &&
                    ((lock_cur.owner_p2 ? p2 : p1) == lock_cur.move);
    res       = ROUND_VOID;
    lock_next = lock_cur;
    if (!missing_move && !locked_repeat) begin
      if (p1 == p2) begin
        res       = ROUND_DRAW;
        lock_next = '0;
      end else if (beats(p1, p2)) begin
        res       = ROUND_P1;
        lock_next = '{valid: 1'b1, owner_p2: 1'b0, move: p1};
      end else begin
        res       = ROUND_P2;
        lock_next = '{valid: 1'b1, owner_p2: 1'b1, move: p2};
      end
    end
  end

endmodule

// File: rtl/morra_match_engine.sv
// Morra match engine: match FSM, score/played counters, advantage register and end check.
module morra_match_engine
  import morra_pkg::*;
#(
  parameter int MIN_ROUNDS = DEF_MIN_ROUNDS,
  parameter int WIN_MARGIN = DEF_WIN_MARGIN,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             move_valid,
  input  logic [1:0]       p1,
  input  logic [1:0]       p2,
  output logic             busy,
  output logic             round_valid,
  output logic [1:0]       round,
  output logic [1:0]       game,
  output logic [CNT_W-1:0] score_p1,
  output logic [CNT_W-1:0] score_p2,
  output logic [CNT_W-1:0] played
);

  // Counters must hold the longest possible match (MIN_ROUNDS plus 15 extra rounds).
  if ((2 ** CNT_W) <= (MIN_ROUNDS + 15)) begin : g_cnt_w_check
    $error("morra_match_engine: CNT_W too small for MIN_ROUNDS+15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_ROUNDS);
  localparam logic [CNT_W:0]   ADV_ONE    = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   MARGIN_MAG = (CNT_W+1)'(WIN_MARGIN);

  state_e            state;
  lock_t             lock;
  lock_t             lock_judged;
  round_res_e        res;
  logic [CNT_W:0]    adv;
  logic [CNT_W:0]    adv_next;
  logic [CNT_W:0]    adv_mag;
  logic [CNT_W-1:0]  max_rounds;
  logic [CNT_W-1:0]  played_next;
  logic [CNT_W-1:0]  score_p1_next;
  logic [CNT_W-1:0]  score_p2_next;
  logic              decided;
  logic              match_end;
  game_res_e         game_next;

  morra_round_judge u_judge (
    .p1        (move_e'(p1)),
    .p2        (move_e'(p2)),
    .lock_cur  (lock),
    .res       (res),
    .lock_next (lock_judged)
  );

  // Post-round counter values and the end-of-match decision for the current moves.
  always_comb begin
    decided       = (res != ROUND_VOID);
    played_next   = played;
    score_p1_next = score_p1;
    score_p2_next = score_p2;
    adv_next      = adv;
    if (decided && (played != CNT_MAX)) begin
      played_next = played + CNT_ONE;
    end
    if (res == ROUND_P1) begin
      if (score_p1 != CNT_MAX) begin
        score_p1_next = score_p1 + CNT_ONE;
      end
      adv_next = adv + ADV_ONE;
    end else if (res == ROUND_P2) begin
      if (score_p2 != CNT_MAX) begin
        score_p2_next = score_p2 + CNT_ONE;
      end
      adv_next = adv - ADV_ONE;
    end
    adv_mag   = adv_next[CNT_W] ? ((~adv_next) + ADV_ONE) : adv_next;
    match_end = decided && (played_next >= MIN_CNT) &&
                ((adv_mag >= MARGIN_MAG) || (played_next == max_rounds));
    if (adv_next[CNT_W]) begin
      game_next = GAME_P2;
    end else if (adv_next == '0) begin
      game_next = GAME_TIE;
    end else begin
      game_next = GAME_P1;
    end
  end

  // Match FSM with registered outputs; start overrides everything, including a same-cycle move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      round_valid <= 1'b0;
      round       <= ROUND_VOID;
      game        <= GAME_NONE;
      score_p1    <= '0;
      score_p2    <= '0;
      played      <= '0;
      adv         <= '0;
      lock        <= '0;
      max_rounds  <= MIN_CNT;
    end else begin
      round_valid <= 1'b0;
      if (start) begin
        state      <= S_PLAY;
        busy       <= 1'b1;
        game       <= GAME_NONE;
        score_p1   <= '0;
        score_p2   <= '0;
        played     <= '0;
        adv        <= '0;
        lock       <= '0;
        max_rounds <= MIN_CNT + CNT_W'({p1, p2});
      end else begin
        case (state)
          S_PLAY: begin
            if (move_valid) begin
              round_valid <= 1'b1;
              round       <= res;
              score_p1    <= score_p1_next;
              score_p2    <= score_p2_next;
              played      <= played_next;
              adv         <= adv_next;
              lock        <= lock_judged;
              if (match_end) begin
                state <= S_DONE;
                busy  <= 1'b0;
                game  <= game_next;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morra_match_engine.sv
// Self-checking bench for morra_match_engine: rule-level model compared every cycle plus directed literal checks.
module tb_morra_match_engine;

  localparam int MIN_R  = 4;
  localparam int MARGIN = 2;
  localparam int CW     = 5;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          move_valid = 1'b0;
  logic [1:0]    p1 = 2'b00;
  logic [1:0]    p2 = 2'b00;
  logic          busy;
  logic          round_valid;
  logic [1:0]    round;
  logic [1:0]    game;
  logic [CW-1:0] score_p1;
  logic [CW-1:0] score_p2;
  logic [CW-1:0] played;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, expressed directly in terms of the game rules.
  int m_s1 = 0, m_s2 = 0, m_played = 0, m_adv = 0;
  int m_lock_who = 0, m_lock_mv = 0, m_max = MIN_R;
  int m_game = 0, m_round = 0;
  bit m_play = 0, m_rv = 0;

  morra_match_engine #(
    .MIN_ROUNDS (MIN_R),
    .WIN_MARGIN (MARGIN),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .move_valid  (move_valid),
    .p1          (p1),
    .p2          (p2),
    .busy        (busy),
    .round_valid (round_valid),
    .round       (round),
    .game        (game),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .played      (played)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit mv, input int a, input int b);
    start      = s;
    move_valid = mv;
    p1         = 2'(a);
    p2         = 2'(b);
    @(negedge clk);
  endtask

  // Round outcome from the rules: 0 void, 1 P1, 2 P2, 3 draw.
  function automatic int judge(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    if (m_lock_who == 1 && a == m_lock_mv) return 0;
    if (m_lock_who == 2 && b == m_lock_mv) return 0;
    if (a == b) return 3;
    if (((a - b + 3) % 3) == 1) return 1;
    return 2;
  endfunction

  // Model update on each clock edge, or immediately on reset.
  always @(posedge clk or negedge rst_n) begin
    int r;
    int mag;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_played = 0; m_adv = 0;
      m_lock_who = 0; m_lock_mv = 0; m_max = MIN_R;
      m_game = 0; m_round = 0; m_play = 0; m_rv = 0;
    end else begin
      m_rv = 0;
      if (start) begin
        m_s1 = 0; m_s2 = 0; m_played = 0; m_adv = 0;
        m_lock_who = 0; m_lock_mv = 0; m_game = 0;
        m_max  = MIN_R + int'({p1, p2});
        m_play = 1;
      end else if (m_play && move_valid) begin
        r = judge(int'(p1), int'(p2));
        m_rv    = 1;
        m_round = r;
        if (r == 1) begin
          if (m_s1 < CMAX) m_s1++;
          m_adv++;
          m_lock_who = 1; m_lock_mv = int'(p1);
        end else if (r == 2) begin
          if (m_s2 < CMAX) m_s2++;
          m_adv--;
          m_lock_who = 2; m_lock_mv = int'(p2);
        end else if (r == 3) begin
          m_lock_who = 0; m_lock_mv = 0;
        end
        if (r != 0) begin
          if (m_played < CMAX) m_played++;
          mag = (m_adv < 0) ? -m_adv : m_adv;
          if (m_played >= MIN_R && (mag >= MARGIN || m_played == m_max)) begin
            m_play = 0;
            m_game = (m_adv > 0) ? 1 : ((m_adv < 0) ? 2 : 3);
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    checkOutput("cyc_busy",        32'(busy),        32'(m_play));
    checkOutput("cyc_round_valid", 32'(round_valid), 32'(m_rv));
    checkOutput("cyc_round",       32'(round),       32'(m_round));
    checkOutput("cyc_game",        32'(game),        32'(m_game));
    checkOutput("cyc_score_p1",    32'(score_p1),    32'(m_s1));
    checkOutput("cyc_score_p2",    32'(score_p2),    32'(m_s2));
    checkOutput("cyc_played",      32'(played),      32'(m_played));
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);

    // Reset in the middle of a match at 1-0.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 3);
    checkOutput("t1_score_before_reset", 32'(score_p1), 32'd1);
    applyStimulus(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1_busy_reset",   32'(busy),     32'd0);
    checkOutput("t1_score_reset",  32'(score_p1), 32'd0);
    checkOutput("t1_played_reset", 32'(played),   32'd0);
    checkOutput("t1_round_reset",  32'(round),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);

    // Margin win at exactly MIN_ROUNDS decided rounds.
    applyStimulus(1, 0, 0, 0);
    checkOutput("t2_busy_after_start", 32'(busy),        32'd1);
    checkOutput("t2_no_rv_on_start",   32'(round_valid), 32'd0);
    applyStimulus(0, 1, 1, 3);
    checkOutput("t2_round1", 32'(round), 32'd1);
    applyStimulus(0, 1, 2, 1);
    checkOutput("t2_round2", 32'(round), 32'd1);
    applyStimulus(0, 1, 1, 1);
    checkOutput("t2_round3", 32'(round), 32'd3);
    checkOutput("t2_game_in_progress", 32'(game), 32'd0);
    applyStimulus(0, 1, 2, 2);
    checkOutput("t2_round4", 32'(round),       32'd3);
    checkOutput("t2_rv4",    32'(round_valid), 32'd1);
    checkOutput("t2_played", 32'(played),      32'd4);
    checkOutput("t2_game",   32'(game),        32'd1);
    checkOutput("t2_busy",   32'(busy),        32'd0);

    // Moves held in DONE are ignored.
    applyStimulus(0, 1, 1, 3);
    applyStimulus(0, 1, 3, 2);
    checkOutput("t4_done_rv",     32'(round_valid), 32'd0);
    checkOutput("t4_done_played", 32'(played),      32'd4);
    checkOutput("t4_done_game",   32'(game),        32'd1);

    // Lock rule and missing-move void rounds.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 3);
    applyStimulus(0, 1, 1, 2);
    checkOutput("t3_locked_void",   32'(round),  32'd0);
    checkOutput("t3_locked_played", 32'(played), 32'd1);
    applyStimulus(0, 1, 3, 2);
    checkOutput("t3_after_lock",    32'(round),  32'd1);
    applyStimulus(0, 1, 1, 0);
    checkOutput("t4_p2_none_round", 32'(round),    32'd0);
    checkOutput("t4_p2_none_score", 32'(score_p1), 32'd2);

    // Start together with a move restarts and drops the move.
    applyStimulus(1, 1, 2, 1);
    checkOutput("t6_rv",     32'(round_valid), 32'd0);
    checkOutput("t6_played", 32'(played),      32'd0);
    checkOutput("t6_busy",   32'(busy),        32'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t6_no_late_rv", 32'(round_valid), 32'd0);

    // max_rounds = 5, alternating wins ending on the round limit with P1 ahead.
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 1, 1, 3);
    applyStimulus(0, 1, 3, 1);
    applyStimulus(0, 1, 1, 3);
    applyStimulus(0, 1, 3, 1);
    checkOutput("t5_game_after4", 32'(game), 32'd0);
    applyStimulus(0, 1, 1, 3);
    checkOutput("t5_game",   32'(game),   32'd1);
    checkOutput("t5_played", 32'(played), 32'd5);

    // Same, but the fifth round is a draw: tie.
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 1, 1, 3);
    applyStimulus(0, 1, 3, 1);
    applyStimulus(0, 1, 1, 3);
    applyStimulus(0, 1, 3, 1);
    applyStimulus(0, 1, 2, 2);
    checkOutput("t5_tie_game", 32'(game), 32'd3);
    checkOutput("t5_tie_busy", 32'(busy), 32'd0);

    // P2 runs away with varied moves: ends on margin at played=4.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 3, 1);
    applyStimulus(0, 1, 1, 2);
    applyStimulus(0, 1, 2, 3);
    checkOutput("t7_busy_mid", 32'(busy), 32'd1);
    applyStimulus(0, 1, 3, 1);
    checkOutput("t7_game",  32'(game),     32'd2);
    checkOutput("t7_score", 32'(score_p2), 32'd4);

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morra_match_engine.md
# morra_match_engine

Parametrised successor of the two-player morra cinese (rock/paper/scissors) game FSM. It accepts one pair of moves per handshake, judges each round under the "winner may not repeat its winning move" rule, and tracks scores and advantage. It closes the match on a configurable margin or round limit and holds the match result until the next `start`. It sits between the player input front-end and the result/display logic.

## Interface
- `MIN_ROUNDS`, default 4: decided (non-void) rounds that must be played before the margin can end the match.
- `WIN_MARGIN`, default 2: absolute advantage that ends the match once `MIN_ROUNDS` is reached.
- `CNT_W`, default 5: width of the round and score counters. Must satisfy `2**CNT_W > MIN_ROUNDS+15`; elaboration fails otherwise.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin or restart a match. `{p1,p2}` are sampled as the extra-round count.
- `move_valid` in 1: `p1`/`p2` hold a round's moves this cycle.
- `p1`, `p2` in 2: move code. 00 = none/invalid, 01 = rock, 10 = paper, 11 = scissors.
- `busy` out 1: high in PLAY.
- `round_valid` out 1: one-cycle pulse, `round` is valid.
- `round` out 2: round result. 00 = void, 01 = P1, 10 = P2, 11 = draw.
- `game` out 2: match result. 00 = in progress/none, 01 = P1, 10 = P2, 11 = tie.
- `score_p1`, `score_p2` out `CNT_W`: rounds won by each player.
- `played` out `CNT_W`: decided rounds (wins plus draws).

## Operation
- The FSM has three states: IDLE, PLAY, DONE.
  - Reset enters IDLE.
  - `start` in any state goes to PLAY. It clears the scores, `played`, the advantage, the lock and `game`. It latches `max_rounds = MIN_ROUNDS + {p1,p2}` (range 4..19 at default).
  - In PLAY, each cycle with `move_valid=1` is one round. `move_valid` is ignored in IDLE and DONE.
- Beats relation: rock beats scissors, paper beats rock, scissors beats paper. Equal non-zero moves are a draw.
- Void round (`round=00`): either move is 00, or the lock is set and the locked winner plays its locked move.
  - A void round changes nothing except the `round_valid` pulse.
- Win: the winner's score increments and the advantage changes by ±1 (signed, `CNT_W+1` bits, + toward P1). The lock is set to {winner, winning move}. `played` increments.
- Draw: the lock is cleared and `played` increments.
- End check runs after every decided round. The match ends when `played >= MIN_ROUNDS` and either `|adv| >= WIN_MARGIN` or `played == max_rounds`.
  - On end, the FSM moves to DONE. `game` becomes 01 if adv>0, 10 if adv<0, 11 if adv==0.
- DONE holds `game`, the scores and `played` until `start` or reset.
- Counters saturate at their maximum value; they never wrap.

## Timing
- Reset values: `busy=0`, `round_valid=0`, `round=00`, `game=00`, scores=0, `played=0`. Internally, adv=0, lock clear, `max_rounds=MIN_ROUNDS`.
- `start` at edge N: `busy=1` from N+1 and `game=00` from N+1. No `round_valid` is produced for the `start` cycle.
- `start` and `move_valid` in the same cycle: `start` wins and the move is discarded.
- Round latency is 1 cycle. A move accepted at edge N gives `round_valid`/`round` and updated scores/`played` after edge N. `round` holds its value until the next accepted round.
- On the final round, `game` becomes non-zero and `busy` falls on the same edge as that round's `round_valid`.
- Back-to-back `move_valid` is allowed every cycle. The lock from round k applies to round k+1 with no bubble.
- A reset mid-match returns to reset values immediately (asynchronous). No result is reported for the aborted match.

## Structure
- `morra_pkg` holds:
  - Enums `move_e`, `round_res_e`, `game_res_e`.
  - Function `beats(a,b)`.
  - Default parameter constants.
- Sub-module `morra_round_judge` (combinational): takes the moves and the lock, returns the round result and the new lock.
- The top level holds the FSM, counters, the advantage register and the end check.

## Test plan
1. Reset mid-PLAY with score 1-0 -> all outputs zero immediately; `busy=0`.
2. `start` with `{p1,p2}=0000`, then rounds rock/scissors, paper/rock, rock/rock, paper/paper -> `round` 01, 01, 11, 11; `played=4`. `game=01` on the 4th `round_valid`.
3. After P1 wins with rock, next round rock/paper -> `round=00`, `played` unchanged. Then scissors/paper -> `round=01`.
4. Moves with `p2=00`, and `move_valid` held high in DONE -> `round=00`, no counter change. Nothing is accepted in DONE.
5. `start` with `{p1,p2}=0001` (`max_rounds=5`), then alternate P1/P2 wins for 5 rounds -> `game=01` after round 5 (adv=+1). Variant with 4 alternating wins then a draw -> `game=11`.
6. `start` asserted together with `move_valid` in PLAY -> the match restarts, the move is dropped, and no `round_valid` follows.
